level_map_server: RTL and testbench

- Owns the level grid: 64x32 cells, each a 3-bit cell type (0 = empty, nonzero = solid).
- Answers cell lookups from the player updater (port 0) and the renderer/raycaster (port 1). These clients put out grid_x/grid_y and take back grid_out.
- Accepts cell writes for doors and pickups. Fills the border walls itself after reset.
- Sits between the game logic and the single-port map RAM. Arbitrates one memory access per clock.

---
 rtl/level_map_server_pkg.sv | 29 ++
 rtl/level_map_ram.sv | 22 ++
 rtl/level_map_server.sv | 117 +++++++++++
 tb/tb_level_map_server.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/level_map_server_pkg.sv
// Shared level-grid definitions used by the map server, the player updater and the renderer.
package level_map_server_pkg;

  localparam int GX_BITS   = 6;
  localparam int GY_BITS   = 5;
  localparam int CELL_BITS = 3;
  localparam int ADDR_BITS = GX_BITS + GY_BITS;
  localparam int GRID_W    = 64;
  localparam int GRID_H    = 32;

  localparam logic [CELL_BITS-1:0] CELL_EMPTY = 3'd0;
  localparam logic [CELL_BITS-1:0] CELL_WALL  = 3'd1;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  // Address is {y, x}; a cell is on the border if it sits on any outer row or column.
  function automatic logic is_border(input logic [ADDR_BITS-1:0] addr);
    logic [GX_BITS-1:0] x;
    logic [GY_BITS-1:0] y;
    x = addr[GX_BITS-1:0];
    y = addr[ADDR_BITS-1:GX_BITS];
    return (x == '0) || (x == GX_BITS'(GRID_W - 1)) ||
           (y == '0) || (y == GY_BITS'(GRID_H - 1));
  endfunction

endpackage

// File: rtl/level_map_ram.sv
// Single-port synchronous map RAM: registered read data, one cycle read latency.
module level_map_ram
  import level_map_server_pkg::*;
#(
  parameter int AW = ADDR_BITS,
  parameter int DW = CELL_BITS
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    else    rdata     <= mem[addr];
  end

endmodule

// File: rtl/level_map_server.sv
// Level grid owner: border-fill sweep after reset, then one arbitrated RAM access per clock.
//   state    | meaning
//   ST_INIT  | sweeping all 2048 cells, border = BORDER_CELL, interior = empty; requests ignored
//   ST_SERVE | ready; write first, then round-robin between the two read ports
module level_map_server
  import level_map_server_pkg::*;
#(
  parameter logic [CELL_BITS-1:0] BORDER_CELL = CELL_WALL
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 ready,
  input  logic                 rd0_req,
  input  logic [GX_BITS-1:0]   rd0_x,
  input  logic [GY_BITS-1:0]   rd0_y,
  output logic                 rd0_ack,
  output logic [CELL_BITS-1:0] rd0_data,
  input  logic                 rd1_req,
  input  logic [GX_BITS-1:0]   rd1_x,
  input  logic [GY_BITS-1:0]   rd1_y,
  output logic                 rd1_ack,
  output logic [CELL_BITS-1:0] rd1_data,
  input  logic                 wr_req,
  input  logic [GX_BITS-1:0]   wr_x,
  input  logic [GY_BITS-1:0]   wr_y,
  input  logic [CELL_BITS-1:0] wr_data,
  output logic                 wr_ack
);

  localparam logic [ADDR_BITS-1:0] SWEEP_LAST = '1;

  state_t               state;
  logic [ADDR_BITS-1:0] sweep;
  logic                 rr_next;
  logic                 rd0_elig, rd1_elig;
  logic                 gnt_wr, gnt_rd0, gnt_rd1;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [CELL_BITS-1:0] ram_wdata, ram_rdata;
  logic [CELL_BITS-1:0] rd0_hold, rd1_hold;

  // A port whose ack is high this cycle is already served; skipping it avoids a double grant.
  always_comb begin
    rd0_elig  = rd0_req && !rd0_ack;
    rd1_elig  = rd1_req && !rd1_ack;
    gnt_wr    = 1'b0;
    gnt_rd0   = 1'b0;
    gnt_rd1   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = sweep;
    ram_wdata = is_border(sweep) ? BORDER_CELL : CELL_EMPTY;
    if (state == ST_INIT) begin
      ram_we = 1'b1;
    end else if (wr_req && !wr_ack) begin
      gnt_wr    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = {wr_y, wr_x};
      ram_wdata = wr_data;
    end else if (rd0_elig && (!rd1_elig || !rr_next)) begin
      gnt_rd0  = 1'b1;
      ram_addr = {rd0_y, rd0_x};
    end else if (rd1_elig) begin
      gnt_rd1  = 1'b1;
      ram_addr = {rd1_y, rd1_x};
    end
  end

  level_map_ram #(
    .AW (ADDR_BITS),
    .DW (CELL_BITS)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      sweep    <= '0;
      ready    <= 1'b0;
      rr_next  <= 1'b0;
      wr_ack   <= 1'b0;
      rd0_ack  <= 1'b0;
      rd1_ack  <= 1'b0;
      rd0_hold <= '0;
      rd1_hold <= '0;
    end else begin
      wr_ack  <= gnt_wr;
      rd0_ack <= gnt_rd0;
      rd1_ack <= gnt_rd1;
      if (rd0_ack) rd0_hold <= ram_rdata;
      if (rd1_ack) rd1_hold <= ram_rdata;
      case (state)
        ST_INIT: begin
          sweep <= sweep + ADDR_BITS'(1);
          if (sweep == SWEEP_LAST) begin
            state <= ST_SERVE;
            ready <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (gnt_rd0)      rr_next <= 1'b1;
          else if (gnt_rd1) rr_next <= 1'b0;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // RAM output is live during the ack cycle; afterwards the captured copy holds it.
  assign rd0_data = rd0_ack ? ram_rdata : rd0_hold;
  assign rd1_data = rd1_ack ? ram_rdata : rd1_hold;

endmodule

// File: tb/tb_level_map_server.sv
// Directed and random checks of level_map_server against a flat-array model of the grid.
module tb_level_map_server;
  import level_map_server_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 ready;
  logic                 rd0_req, rd1_req, wr_req;
  logic [GX_BITS-1:0]   rd0_x, rd1_x, wr_x;
  logic [GY_BITS-1:0]   rd0_y, rd1_y, wr_y;
  logic [CELL_BITS-1:0] wr_data, rd0_data, rd1_data;
  logic                 rd0_ack, rd1_ack, wr_ack;

  int total = 0;
  int bad   = 0;
  logic [CELL_BITS-1:0] model [GRID_W*GRID_H];

  always #5 clock = ~clock;

  level_map_server dut (
    .clock    (clock),
    .reset    (reset),
    .ready    (ready),
    .rd0_req  (rd0_req),
    .rd0_x    (rd0_x),
    .rd0_y    (rd0_y),
    .rd0_ack  (rd0_ack),
    .rd0_data (rd0_data),
    .rd1_req  (rd1_req),
    .rd1_x    (rd1_x),
    .rd1_y    (rd1_y),
    .rd1_ack  (rd1_ack),
    .rd1_data (rd1_data),
    .wr_req   (wr_req),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int idx(input int x, input int y);
    return y * GRID_W + x;
  endfunction

  task automatic model_init();
    for (int y = 0; y < GRID_H; y++)
      for (int x = 0; x < GRID_W; x++)
        model[idx(x, y)] = (x == 0 || x == GRID_W-1 || y == 0 || y == GRID_H-1) ? 3'd1 : 3'd0;
  endtask

  // Counts cycles from the current point until ready is seen, tallying any acks on the way.
  task automatic wait_ready(output int cycles, output int acks);
    cycles = 0;
    acks   = 0;
    while (!ready && cycles < 3000) begin
      tick();
      cycles++;
      if (rd0_ack || rd1_ack || wr_ack) acks++;
    end
  endtask

  task automatic do_read(input int port, input int x, input int y,
                         output logic [CELL_BITS-1:0] data, output int lat);
    logic got;
    got  = 1'b0;
    lat  = 0;
    data = 'x;
    if (port == 0) begin
      rd0_x = GX_BITS'(x); rd0_y = GY_BITS'(y); rd0_req = 1'b1;
    end else begin
      rd1_x = GX_BITS'(x); rd1_y = GY_BITS'(y); rd1_req = 1'b1;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      lat++;
      if (port == 0 && rd0_ack) begin got = 1'b1; data = rd0_data; end
      if (port == 1 && rd1_ack) begin got = 1'b1; data = rd1_data; end
    end
    if (port == 0) rd0_req = 1'b0;
    else           rd1_req = 1'b0;
    check("read_ack_seen", got, 1);
    tick();
  endtask

  task automatic do_write(input int x, input int y, input logic [CELL_BITS-1:0] d,
                          output int lat);
    logic got;
    got     = 1'b0;
    lat     = 0;
    wr_x    = GX_BITS'(x);
    wr_y    = GY_BITS'(y);
    wr_data = d;
    wr_req  = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      lat++;
      if (wr_ack) got = 1'b1;
    end
    wr_req = 1'b0;
    check("write_ack_seen", got, 1);
    model[idx(x, y)] = d;
    tick();
  endtask

  initial begin
    int cycles, acks, lat, x, y, op;
    logic [CELL_BITS-1:0] d, wd;

    reset   = 1'b1;
    rd0_req = 1'b0; rd1_req = 1'b0; wr_req = 1'b0;
    rd0_x = '0; rd0_y = '0; rd1_x = '0; rd1_y = '0;
    wr_x = '0; wr_y = '0; wr_data = '0;
    model_init();
    tick(); tick();
    check("rst_ready", ready, 0);
    check("rst_rd0_ack", rd0_ack, 0);
    check("rst_rd1_ack", rd1_ack, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_rd0_data", rd0_data, 0);
    check("rst_rd1_data", rd1_data, 0);

    // Requests held through the sweep must be ignored, including a write.
    rd0_req = 1'b1;
    wr_x = 6'd30; wr_y = 5'd10; wr_data = 3'd7; wr_req = 1'b1;
    reset = 1'b0;
    wait_ready(cycles, acks);
    rd0_req = 1'b0;
    wr_req  = 1'b0;
    check("ready_cycles", cycles, 2048);
    check("init_acks", acks, 0);

    do_read(0, 0, 0, d, lat);   check("rd0_00", d, model[idx(0, 0)]);   check("rd0_00_lat", lat, 1);
    do_read(0, 63, 31, d, lat); check("rd0_6331", d, model[idx(63, 31)]); check("rd0_6331_lat", lat, 1);
    do_read(0, 0, 17, d, lat);  check("rd0_017", d, model[idx(0, 17)]);  check("rd0_017_lat", lat, 1);
    do_read(0, 5, 5, d, lat);   check("rd0_55", d, model[idx(5, 5)]);   check("rd0_55_lat", lat, 1);
    check("rd0_held", rd0_data, model[idx(5, 5)]);
    do_read(1, 30, 10, d, lat); check("init_write_ignored", d, model[idx(30, 10)]);

    do_write(10, 4, 3'b010, lat); check("wr_lat", lat, 1);
    do_read(1, 10, 4, d, lat);    check("rd1_104", d, 3'b010); check("rd1_104_lat", lat, 1);
    do_read(1, 11, 4, d, lat);    check("rd1_114", d, model[idx(11, 4)]);

    // Write and read to the same cell in one cycle: write first, read sees new value.
    wr_x = 6'd20; wr_y = 5'd20; wr_data = 3'b011; wr_req = 1'b1;
    rd0_x = 6'd20; rd0_y = 5'd20; rd0_req = 1'b1;
    tick();
    check("coll_wr_ack", wr_ack, 1);
    check("coll_rd0_wait", rd0_ack, 0);
    wr_req = 1'b0;
    model[idx(20, 20)] = 3'b011;
    tick();
    check("coll_rd0_ack", rd0_ack, 1);
    check("coll_rd0_data", rd0_data, 3'b011);
    rd0_req = 1'b0;
    tick();

    // Reset from SERVE, then again 1000 cycles into the sweep.
    check("pre_reset_ready", ready, 1);
    reset = 1'b1;
    #1;
    check("ready_falls", ready, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 1000; i++) tick();
    check("mid_init_ready", ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_init();
    wait_ready(cycles, acks);
    check("ready_cycles_2", cycles, 2048);

    // Both reads held: port 0 wins first after reset, then strict alternation.
    rd0_x = 6'd0; rd0_y = 5'd3; rd0_req = 1'b1;
    rd1_x = 6'd7; rd1_y = 5'd7; rd1_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("rr_rd0_ack", rd0_ack, (i % 2 == 1) ? 1 : 0);
      check("rr_rd1_ack", rd1_ack, (i % 2 == 0) ? 1 : 0);
      check("rr_rd0_data", rd0_data, model[idx(0, 3)]);
      if (i >= 2) check("rr_rd1_data", rd1_data, model[idx(7, 7)]);
    end
    rd0_req = 1'b0;
    rd1_req = 1'b0;
    tick(); tick();

    do_read(0, 0, 0, d, lat);  check("reinit_00", d, 3'd1);
    do_read(1, 10, 4, d, lat); check("reinit_104", d, model[idx(10, 4)]);
    do_read(0, 20, 20, d, lat); check("reinit_2020", d, model[idx(20, 20)]);

    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 2));
      x  = int'($urandom_range(0, GRID_W-1));
      y  = int'($urandom_range(0, GRID_H-1));
      if (op == 2) begin
        wd = CELL_BITS'($urandom_range(0, 7));
        do_write(x, y, wd, lat);
        check("rand_wr_lat", lat, 1);
      end else begin
        do_read(op, x, y, d, lat);
        check("rand_rd_data", d, model[idx(x, y)]);
        check("rand_rd_lat", lat, 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
